cu_sequencer: RTL and testbench
===============================

// Module: cu_sequencer
// PURPOSE
//  Control-unit sequencer between instruction memory and the IW decoders.
//  Owns the 2-bit micro-state register fed to every decoder and holds the instruction word stable across multi-cycle ops (e.g. MOVK: mask then OR).
//  Gates the selected decoder control word before it reaches the datapath, and handles stall, halt/resume, a watchdog fault and retire accounting.
// PARAMETERS
//  COUNT_W  32  width of retired-instruction counter (wraps)
//  MAX_CYC  4   max consecutive non-00 micro-states before fault (>=2)
// PORTS
//  clock      in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  I_mem      in   32  instruction word from instruction memory (addressed by PC)
//  cw_dec     in   33  control word from decoder mux, driven by (ir, state)
//  k_dec      in   64  constant K from decoder mux
//  stall      in   1   datapath/RAM busy; freeze sequencing this cycle
//  halt_req   in   1   request halt at next instruction boundary
//  resume     in   1   leave HALTED
//  ir         out  32  instruction to decoders
//  state      out  2   micro-state to decoders
//  cw         out  33  gated control word to datapath
//  K          out  64  constant to datapath (k_dec passed through)
//  retire     out  1   one-cycle pulse per completed instruction
//  halted     out  1   in HALTED mode
//  fault      out  1   in FAULT mode (sticky until reset)
//  instr_count out COUNT_W  retired instruction count
// BEHAVIOUR
//  cw field map: [32] reserved 0, [31] alu_en, [30] alu_bs, [29:25] alu_fs, [24] rf_b_en, [23:19] sa, [18:14] sb, [13:9] da, [8] rf_w, [7] ram_en, [6] ram_w, [5:4] pc_fs, [3] pc_is, [2] status_ld, [1:0] next_state.
//  Reset (async, reset=0): state=00, ir_q=0, mode=RUN, wd=0, retire=0, halted=0, fault=0, instr_count=0.
//  ir = (state==00) ? I_mem : ir_q (combinational). ir_q <= I_mem on any advancing edge taken from state 00.
//  Modes: RUN, HALTED, FAULT. "advance" = mode==RUN && !stall.
//  advance: state <= cw_dec[1:0]; else state holds.
//  Gating: when !advance, cw = cw_dec with rf_w, ram_w and status_ld forced 0 and pc_fs forced 00. When advance, cw = cw_dec with bit 32 forced 0.
//  Completion edge: advance && cw_dec[1:0]==00. Set retire=1 for the next cycle only and increment instr_count mod 2^COUNT_W.
//  This covers single-cycle ops (state 00 -> 00) and the final step of multi-cycle ops.
//  Watchdog wd: cleared on any advance into 00. Incremented on each advance into a non-00 state; stall cycles do not count.
//  If an advance would make wd==MAX_CYC, mode <= FAULT instead. In that case state <= 00 and no retire.
//  Halt: halt_req is sampled only on a completion edge. If set, mode <= HALTED after that instruction retires (retire still pulses). Never halts mid-instruction.
//  HALTED: state stays 00. resume=1 gives mode <= RUN on the next edge. halt_req && resume together while HALTED: resume wins.
//  FAULT: absorbing; only reset exits. cw gated, state 00, counters frozen.
//  halted/fault are registered decodes of mode (high in the same cycle mode is HALTED/FAULT).
//  Reset mid-instruction: all state returns to reset values immediately. Partial datapath writes are not undone.
//  stall in the same cycle as a completion: no completion, no retire. Retried when stall drops.
// TESTING
//  MOVK 0xF2A...: cw_dec next_state 01 then 00, no stall -> state 00,01,00; rf_w seen twice; retire pulses once; instr_count=1.
//  MOVK with stall=1 in state 01 for 3 cycles -> state held 01, cw rf_w=0, pc_fs=00, wd unchanged; completes on 1st unstalled cycle.
//  halt_req=1 during state 01 of MOVK -> retire pulses, then halted=1, state 00. resume=1 -> halted=0 next cycle.
//  cw_dec next_state stuck at 01, MAX_CYC=4 -> fault=1 at 4th advance, state 00, cw write bits 0; stays until reset.
//  reset=0 asserted mid-MOVK (state 01) -> state=00, ir=I_mem, counters 0, asynchronously, without a clock edge.
//  COUNT_W=4, 17 single-cycle ops -> instr_count 15 -> 0 -> 1; retire pulses 17 times.

Source files
------------

// File: rtl/cu_sequencer_if.sv
// Bus between instruction memory/decoder mux and the control-unit sequencer.
// The slave modport is the sequencer's view; the master modport is the
// environment (instruction memory, decoder mux, datapath).
interface cu_sequencer_if #(
    parameter int COUNT_W = 32
);
    logic [31:0]        I_mem;
    logic [32:0]        cw_dec;
    logic [63:0]        k_dec;
    logic               stall;
    logic               halt_req;
    logic               resume;
    logic [31:0]        ir;
    logic [1:0]         state;
    logic [32:0]        cw;
    logic [63:0]        K;
    logic               retire;
    logic               halted;
    logic               fault;
    logic [COUNT_W-1:0] instr_count;

    modport slave (
        input  I_mem, cw_dec, k_dec, stall, halt_req, resume,
        output ir, state, cw, K, retire, halted, fault, instr_count
    );

    modport master (
        output I_mem, cw_dec, k_dec, stall, halt_req, resume,
        input  ir, state, cw, K, retire, halted, fault, instr_count
    );
endinterface

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: owns the decoder micro-state, latches the
// instruction word for multi-cycle ops, gates the control word, and handles
// stall, halt/resume, a micro-state watchdog and retire accounting.
//
// mode        | meaning
// ------------+-----------------------------------------------------------
// MODE_RUN    | sequencing; advances on every unstalled cycle
// MODE_HALTED | parked at an instruction boundary, state 00, waits resume
// MODE_FAULT  | watchdog tripped; absorbing until reset, outputs gated
module cu_sequencer #(
    parameter int COUNT_W = 32,
    parameter int MAX_CYC = 4
) (
    input logic          clock,
    input logic          reset,
    cu_sequencer_if.slave bus
);
    localparam int WD_W = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_HALTED = 2'd1,
        MODE_FAULT  = 2'd2
    } mode_t;

    mode_t              mode_q;
    logic [1:0]         state_q;
    logic [31:0]        ir_q;
    logic [WD_W-1:0]    wd_q;
    logic               retire_q;
    logic               halted_q;
    logic               fault_q;
    logic [COUNT_W-1:0] count_q;
    logic               advance;
    logic [32:0]        cw_gated;

    assign advance = (mode_q == MODE_RUN) && !bus.stall;

    // Sequencer FSM: micro-state, instruction latch, watchdog and retire count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_RUN;
            state_q  <= 2'b00;
            ir_q     <= '0;
            wd_q     <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            retire_q <= 1'b0;
            unique case (mode_q)
                MODE_RUN: begin
                    if (!bus.stall) begin
                        if (state_q == 2'b00) begin
                            ir_q <= bus.I_mem;
                        end
                        if (bus.cw_dec[1:0] == 2'b00) begin
                            state_q  <= 2'b00;
                            wd_q     <= '0;
                            retire_q <= 1'b1;
                            count_q  <= count_q + COUNT_W'(1);
                            if (bus.halt_req) begin
                                mode_q   <= MODE_HALTED;
                                halted_q <= 1'b1;
                            end
                        end else if (wd_q + WD_W'(1) == WD_W'(MAX_CYC)) begin
                            // A runaway micro-sequence parks in FAULT at state 00.
                            mode_q  <= MODE_FAULT;
                            fault_q <= 1'b1;
                            state_q <= 2'b00;
                        end else begin
                            wd_q    <= wd_q + WD_W'(1);
                            state_q <= bus.cw_dec[1:0];
                        end
                    end
                end
                MODE_HALTED: begin
                    if (bus.resume) begin
                        mode_q   <= MODE_RUN;
                        halted_q <= 1'b0;
                    end
                end
                MODE_FAULT: begin
                end
                default: begin
                    mode_q  <= MODE_FAULT;
                    fault_q <= 1'b1;
                    state_q <= 2'b00;
                end
            endcase
        end
    end

    // Suppress architectural side effects (writes, PC change) whenever not advancing.
    always_comb begin
        cw_gated = bus.cw_dec;
        if (advance) begin
            cw_gated[32] = 1'b0;
        end else begin
            cw_gated[8]   = 1'b0;
            cw_gated[6]   = 1'b0;
            cw_gated[5:4] = 2'b00;
            cw_gated[2]   = 1'b0;
        end
    end

    assign bus.ir          = (state_q == 2'b00) ? bus.I_mem : ir_q;
    assign bus.state       = state_q;
    assign bus.cw          = cw_gated;
    assign bus.K           = bus.k_dec;
    assign bus.retire      = retire_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios with hand-derived
// expectations plus a randomized run against an instruction-level model.
module tb_cu_sequencer;
    localparam int CW = 4;
    localparam int MC = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode 0=run 1=halted 2=fault; steps = non-00 advances
    // taken inside the current instruction.
    int          m_mode;
    int          m_state;
    int          m_steps;
    int          m_retire;
    int          m_count;
    logic [31:0] m_ir;

    cu_sequencer_if #(.COUNT_W(CW)) bus ();

    cu_sequencer #(.COUNT_W(CW), .MAX_CYC(MC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [32:0] mkcw(input logic [1:0] ns);
        logic [32:0] c;
        c = '0;
        c[32] = 1'b1; c[31] = 1'b1; c[8] = 1'b1; c[6] = 1'b1;
        c[5:4] = 2'b11; c[2] = 1'b1; c[1:0] = ns;
        return c;
    endfunction

    function automatic logic [32:0] exp_cw(input logic [32:0] d, input bit moving);
        logic [32:0] r;
        r = d;
        if (moving) r[32] = 1'b0;
        else begin r[8] = 1'b0; r[6] = 1'b0; r[5:4] = 2'b00; r[2] = 1'b0; end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_state = 0; m_steps = 0; m_retire = 0; m_count = 0; m_ir = '0;
    endtask

    task automatic model_edge();
        int ns;
        m_retire = 0;
        if (m_mode == 0 && !bus.stall) begin
            if (m_state == 0) m_ir = bus.I_mem;
            ns = int'(bus.cw_dec[1:0]);
            if (ns == 0) begin
                m_state = 0; m_steps = 0; m_retire = 1;
                m_count = (m_count + 1) % (1 << CW);
                if (bus.halt_req) m_mode = 1;
            end else if (m_steps + 1 >= MC) begin
                m_mode = 2; m_state = 0;
            end else begin
                m_steps++; m_state = ns;
            end
        end else if (m_mode == 1 && bus.resume) begin
            m_mode = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.I_mem = '0; bus.cw_dec = '0; bus.k_dec = '0;
        bus.stall = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        bus.I_mem = 32'h1357_9BDF;
        do_reset();
        reset = 1'b0;
        #1;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.ir !== 32'h1357_9BDF) begin errors++; $display("FAIL reset_ir: got %h want 13579bdf", bus.ir); end
        checks++; if ({bus.retire, bus.halted, bus.fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.retire, bus.halted, bus.fault}); end
        checks++; if (bus.instr_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.instr_count); end
        reset = 1'b1;
    endtask

    task automatic test_movk();
        do_reset();
        bus.I_mem = 32'hF2A0_1234; bus.cw_dec = mkcw(2'b01); bus.k_dec = 64'hA5A5_0000_1111_2222;
        #1;
        checks++; if (bus.cw[8] !== 1'b1 || bus.cw[32] !== 1'b0) begin errors++; $display("FAIL movk_cw0: got %h want rf_w=1 bit32=0", bus.cw); end
        checks++; if (bus.K !== 64'hA5A5_0000_1111_2222) begin errors++; $display("FAIL movk_k: got %h want a5a5000011112222", bus.K); end
        tick();
        bus.I_mem = 32'hDEAD_BEEF; bus.cw_dec = mkcw(2'b00);
        #1;
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL movk_state1: got %0d want 1", bus.state); end
        checks++; if (bus.ir !== 32'hF2A0_1234) begin errors++; $display("FAIL movk_ir_hold: got %h want f2a01234", bus.ir); end
        checks++; if (bus.cw[8] !== 1'b1 || bus.retire !== 1'b0) begin errors++; $display("FAIL movk_step2: got rf_w=%b retire=%b want 1 0", bus.cw[8], bus.retire); end
        tick();
        checks++; if (bus.state !== 2'b00 || bus.retire !== 1'b1 || bus.instr_count !== 4'd1) begin errors++; $display("FAIL movk_done: got st=%0d ret=%b cnt=%0d want 0 1 1", bus.state, bus.retire, bus.instr_count); end
        checks++; if (bus.ir !== 32'hDEAD_BEEF) begin errors++; $display("FAIL movk_ir_live: got %h want deadbeef", bus.ir); end
        bus.cw_dec = mkcw(2'b01);
        tick();
        checks++; if (bus.retire !== 1'b0 || bus.instr_count !== 4'd1) begin errors++; $display("FAIL movk_one_pulse: got ret=%b cnt=%0d want 0 1", bus.retire, bus.instr_count); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.cw_dec = mkcw(2'b01);
        tick();
        bus.stall = 1'b1; bus.cw_dec = mkcw(2'b00);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.cw[8] !== 1'b0 || bus.cw[6] !== 1'b0 || bus.cw[2] !== 1'b0 || bus.cw[5:4] !== 2'b00) begin errors++; $display("FAIL stall_gate%0d: got %h want writes 0", i, bus.cw); end
            tick();
            checks++; if (bus.state !== 2'b01 || bus.retire !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got st=%0d ret=%b want 1 0", i, bus.state, bus.retire); end
        end
        bus.stall = 1'b0;
        #1;
        checks++; if (bus.cw[8] !== 1'b1) begin errors++; $display("FAIL stall_release_cw: got rf_w=%b want 1", bus.cw[8]); end
        tick();
        checks++; if (bus.retire !== 1'b1 || bus.state !== 2'b00 || bus.instr_count !== 4'd1) begin errors++; $display("FAIL stall_complete: got ret=%b st=%0d cnt=%0d want 1 0 1", bus.retire, bus.state, bus.instr_count); end
        // one step, long stall, two more steps, then complete: stalls must not feed the watchdog
        bus.cw_dec = mkcw(2'b01); tick();
        bus.stall = 1'b1; repeat (5) tick();
        bus.stall = 1'b0; bus.cw_dec = mkcw(2'b10); tick(); tick();
        bus.cw_dec = mkcw(2'b00); tick();
        checks++; if (bus.fault !== 1'b0 || bus.retire !== 1'b1 || bus.instr_count !== 4'd2) begin errors++; $display("FAIL stall_wd: got flt=%b ret=%b cnt=%0d want 0 1 2", bus.fault, bus.retire, bus.instr_count); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.halt_req = 1'b1; bus.cw_dec = mkcw(2'b01);
        tick();
        checks++; if (bus.halted !== 1'b0 || bus.state !== 2'b01) begin errors++; $display("FAIL halt_not_mid: got hlt=%b st=%0d want 0 1", bus.halted, bus.state); end
        bus.cw_dec = mkcw(2'b00);
        tick();
        checks++; if (bus.retire !== 1'b1 || bus.halted !== 1'b1 || bus.state !== 2'b00) begin errors++; $display("FAIL halt_enter: got ret=%b hlt=%b st=%0d want 1 1 0", bus.retire, bus.halted, bus.state); end
        bus.halt_req = 1'b0; bus.cw_dec = mkcw(2'b01);
        #1;
        checks++; if (bus.cw[8] !== 1'b0 || bus.cw[5:4] !== 2'b00) begin errors++; $display("FAIL halt_gate: got %h want writes 0", bus.cw); end
        tick();
        checks++; if (bus.state !== 2'b00 || bus.halted !== 1'b1 || bus.retire !== 1'b0) begin errors++; $display("FAIL halt_park: got st=%0d hlt=%b ret=%b want 0 1 0", bus.state, bus.halted, bus.retire); end
        bus.halt_req = 1'b1; bus.resume = 1'b1;
        tick();
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got hlt=%b want 0", bus.halted); end
        bus.halt_req = 1'b0; bus.resume = 1'b0; bus.cw_dec = mkcw(2'b00);
        tick();
        checks++; if (bus.retire !== 1'b1 || bus.instr_count !== 4'd2 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_run_again: got ret=%b cnt=%0d hlt=%b want 1 2 0", bus.retire, bus.instr_count, bus.halted); end
    endtask

    task automatic test_fault();
        do_reset();
        bus.cw_dec = mkcw(2'b01);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.state !== 2'b01 || bus.fault !== 1'b0) begin errors++; $display("FAIL fault_early%0d: got st=%0d flt=%b want 1 0", i, bus.state, bus.fault); end
        end
        tick();
        checks++; if (bus.fault !== 1'b1 || bus.state !== 2'b00 || bus.retire !== 1'b0) begin errors++; $display("FAIL fault_trip: got flt=%b st=%0d ret=%b want 1 0 0", bus.fault, bus.state, bus.retire); end
        #1;
        checks++; if (bus.cw[8] !== 1'b0 || bus.cw[6] !== 1'b0 || bus.cw[2] !== 1'b0 || bus.cw[5:4] !== 2'b00) begin errors++; $display("FAIL fault_gate: got %h want writes 0", bus.cw); end
        bus.cw_dec = mkcw(2'b00); bus.resume = 1'b1;
        repeat (3) tick();
        checks++; if (bus.fault !== 1'b1 || bus.instr_count !== 4'd0 || bus.retire !== 1'b0) begin errors++; $display("FAIL fault_sticky: got flt=%b cnt=%0d ret=%b want 1 0 0", bus.fault, bus.instr_count, bus.retire); end
        bus.resume = 1'b0;
        do_reset();
        #1;
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got flt=%b want 0", bus.fault); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.cw_dec = mkcw(2'b00); tick();
        bus.I_mem = 32'h1111_2222; bus.cw_dec = mkcw(2'b01); tick();
        bus.I_mem = 32'h3333_4444;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.state !== 2'b00 || bus.ir !== 32'h3333_4444) begin errors++; $display("FAIL async_rst_state: got st=%0d ir=%h want 0 33334444", bus.state, bus.ir); end
        checks++; if (bus.instr_count !== 4'd0 || bus.retire !== 1'b0) begin errors++; $display("FAIL async_rst_cnt: got cnt=%0d ret=%b want 0 0", bus.instr_count, bus.retire); end
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        int pulses;
        do_reset();
        set_idle();
        bus.cw_dec = mkcw(2'b00);
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (bus.retire === 1'b1) pulses++;
            if (i == 15) begin checks++; if (bus.instr_count !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d want 15", bus.instr_count); end end
            if (i == 16) begin checks++; if (bus.instr_count !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d want 0", bus.instr_count); end end
            if (i == 17) begin checks++; if (bus.instr_count !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d want 1", bus.instr_count); end end
        end
        checks++; if (pulses != 17) begin errors++; $display("FAIL wrap_pulses: got %0d want 17", pulses); end
    endtask

    task automatic test_random();
        bit moving;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.I_mem    = $urandom;
            bus.k_dec    = {$urandom, $urandom};
            bus.cw_dec   = {1'($urandom), 32'($urandom)};
            bus.cw_dec[1:0] = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.halt_req = ($urandom_range(0, 9) == 0);
            bus.resume   = ($urandom_range(0, 2) == 0);
            #1;
            moving = (m_mode == 0) && !bus.stall;
            checks++;
            if (bus.state !== 2'(m_state) || bus.ir !== ((m_state == 0) ? bus.I_mem : m_ir) ||
                bus.cw !== exp_cw(bus.cw_dec, moving) || bus.K !== bus.k_dec ||
                bus.retire !== 1'(m_retire) || bus.halted !== (m_mode == 1) ||
                bus.fault !== (m_mode == 2) || bus.instr_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL rand_%0d: got st=%0d ret=%b hlt=%b flt=%b cnt=%0d cw=%h want st=%0d ret=%0d mode=%0d cnt=%0d cw=%h",
                         n, bus.state, bus.retire, bus.halted, bus.fault, bus.instr_count, bus.cw,
                         m_state, m_retire, m_mode, m_count, exp_cw(bus.cw_dec, moving));
            end
            tick();
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_movk();
        test_stall();
        test_halt();
        test_fault();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
